ecc2d_decoder: RTL and testbench

ECC2D_DECODER -- requirements
Module: ecc2d_decoder

---
 rtl/ecc2d_decoder.sv | 147 ++++++++++++++
 tb/tb_ecc2d_decoder.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc2d_decoder.sv
// Two-stage SEC-DED decoder for a 16-bit word protected by 16 check bits,
// with valid/ready flow control and saturating corrected/uncorrectable counters.
module ecc2d_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      cw_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      data_out,
  output logic             err_corr,
  output logic             err_uncorr,
  output logic [4:0]       err_loc,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  function automatic logic [15:0] calc_check(input logic [15:0] x);
    logic [15:0] c;
    c[0]  = x[0] ^ x[2];
    c[1]  = x[1] ^ x[3];
    c[2]  = x[3] ^ x[7] ^ x[11] ^ x[15];
    c[3]  = x[1] ^ x[3] ^ x[4] ^ x[6];
    c[4]  = x[4] ^ x[6];
    c[5]  = x[5] ^ x[7];
    c[6]  = x[2] ^ x[6] ^ x[10] ^ x[14];
    c[7]  = x[0] ^ x[2] ^ x[5] ^ x[7];
    c[8]  = x[8] ^ x[10];
    c[9]  = x[9] ^ x[11];
    c[10] = x[1] ^ x[5] ^ x[9] ^ x[13];
    c[11] = x[9] ^ x[11] ^ x[12] ^ x[14];
    c[12] = x[12] ^ x[14];
    c[13] = x[13] ^ x[15];
    c[14] = x[0] ^ x[4] ^ x[8] ^ x[12];
    c[15] = x[8] ^ x[10] ^ x[13] ^ x[15];
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic              vld_p1_q;
  logic [15:0]       data_p1_q;
  logic [15:0]       syn_p1_q;
  logic [15:0]       syn_p1_d;
  logic              vld_p2_q;
  logic [15:0]       data_out_q;
  logic              err_corr_q;
  logic              err_uncorr_q;
  logic [4:0]        err_loc_q;
  logic [CNT_W-1:0]  corr_cnt_q;
  logic [CNT_W-1:0]  uncorr_cnt_q;
  logic              adv_p2;
  logic [15:0]       dec_data;
  logic              dec_corr;
  logic              dec_uncorr;
  logic [4:0]        dec_loc;

  assign adv_p2   = !vld_p2_q || out_ready;
  assign in_ready = !vld_p1_q || adv_p2;
  assign syn_p1_d = calc_check(cw_in[15:0]) ^ cw_in[31:16];

  // ---- stage 1: capture data and syndrome ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
    end else if (in_ready) begin
      vld_p1_q <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      data_p1_q <= cw_in[15:0];
      syn_p1_q  <= syn_p1_d;
    end
  end

  // A lone syndrome bit points at a check bit; a weight-3 match points at a data bit.
  always_comb begin
    dec_data   = data_p1_q;
    dec_corr   = 1'b0;
    dec_uncorr = 1'b0;
    dec_loc    = 5'd0;
    if (syn_p1_q != 16'd0) begin
      if ((syn_p1_q & (syn_p1_q - 16'd1)) == 16'd0) begin
        dec_corr = 1'b1;
        for (int i = 0; i < 16; i++) begin
          if (syn_p1_q[i]) dec_loc = 5'(16 + i);
        end
      end else begin
        for (int i = 0; i < 16; i++) begin
          if (syn_p1_q == calc_check(16'(1) << i)) begin
            dec_data[i] = ~data_p1_q[i];
            dec_corr    = 1'b1;
            dec_loc     = 5'(i);
          end
        end
        dec_uncorr = !dec_corr;
      end
    end
  end

  // ---- stage 2: registered decode result ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q     <= 1'b0;
      data_out_q   <= 16'd0;
      err_corr_q   <= 1'b0;
      err_uncorr_q <= 1'b0;
      err_loc_q    <= 5'd0;
    end else if (adv_p2) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        data_out_q   <= dec_data;
        err_corr_q   <= dec_corr;
        err_uncorr_q <= dec_uncorr;
        err_loc_q    <= dec_loc;
      end
    end
  end

  // ---- counters: only results actually accepted downstream ----
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else if (vld_p2_q && out_ready) begin
      if (err_corr_q)   corr_cnt_q   <= sat_inc(corr_cnt_q);
      if (err_uncorr_q) uncorr_cnt_q <= sat_inc(uncorr_cnt_q);
    end
  end

  assign out_valid  = vld_p2_q;
  assign data_out   = data_out_q;
  assign err_corr   = err_corr_q;
  assign err_uncorr = err_uncorr_q;
  assign err_loc    = err_loc_q;
  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_ecc2d_decoder.sv
// Randomized bench for ecc2d_decoder: a brute-force nearest-codeword model
// plus an in-flight queue predicts every output, ready and counter value.
module tb_ecc2d_decoder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, out_valid, out_ready, cnt_clr;
  logic [31:0] cw_in;
  logic [15:0] data_out, corr_cnt, uncorr_cnt;
  logic        err_corr, err_uncorr;
  logic [4:0]  err_loc;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, cnt_clr2;
  logic [31:0] cw_in2;
  logic [15:0] data_out2;
  logic        err_corr2, err_uncorr2;
  logic [4:0]  err_loc2;
  logic [1:0]  corr_cnt2, uncorr_cnt2;

  ecc2d_decoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .cw_in(cw_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .err_corr(err_corr), .err_uncorr(err_uncorr), .err_loc(err_loc),
    .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  ecc2d_decoder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .cw_in(cw_in2),
    .out_valid(out_valid2), .out_ready(out_ready2), .data_out(data_out2),
    .err_corr(err_corr2), .err_uncorr(err_uncorr2), .err_loc(err_loc2),
    .cnt_clr(cnt_clr2), .corr_cnt(corr_cnt2), .uncorr_cnt(uncorr_cnt2)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] d;
    logic        c;
    logic        u;
    logic [4:0]  l;
    int          t;
  } exp_t;

  // Data bits covered by each check bit 16..31.
  localparam logic [15:0] MASKS [16] = '{
    16'h0005, 16'h000A, 16'h8888, 16'h005A, 16'h0050, 16'h00A0, 16'h4444, 16'h00A5,
    16'h0500, 16'h0A00, 16'h2222, 16'h5A00, 16'h5000, 16'hA000, 16'h1111, 16'hA500};

  function automatic logic [15:0] m_check(input logic [15:0] x);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = ^(x & MASKS[i]);
    return r;
  endfunction

  function automatic logic [31:0] encode(input logic [15:0] x);
    return {m_check(x), x};
  endfunction

  function automatic logic is_cw(input logic [31:0] cw);
    return m_check(cw[15:0]) == cw[31:16];
  endfunction

  // Correct iff exactly one single-bit flip lands on a valid codeword.
  function automatic exp_t m_decode(input logic [31:0] cw);
    exp_t e;
    logic [31:0] f;
    e.d = cw[15:0]; e.c = 1'b0; e.u = 1'b0; e.l = 5'd0; e.t = 0;
    if (!is_cw(cw)) begin
      for (int b = 0; b < 32; b++) begin
        f = cw ^ (32'd1 << b);
        if (is_cw(f)) begin
          e.c = 1'b1; e.l = 5'(b); e.d = f[15:0];
        end
      end
      e.u = !e.c;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_cw();
    logic [31:0] cw;
    int b1, b2;
    cw = encode(16'($urandom));
    b1 = $urandom_range(0, 31);
    b2 = (b1 + $urandom_range(1, 31)) % 32;
    case ($urandom_range(0, 3))
      1: cw[b1] = ~cw[b1];
      2: begin cw[b1] = ~cw[b1]; cw[b2] = ~cw[b2]; end
      3: cw = $urandom;
      default: ;
    endcase
    return cw;
  endfunction

  task automatic step(input logic v, input logic [31:0] cw, input logic ordy);
    @(negedge clk);
    in_valid = v; cw_in = cw; out_ready = ordy;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step(1'b0, $urandom, 1'b1);
    rst = 1'b0;
    step(1'b0, $urandom, 1'b1);
    vectors++;
    if ({in_ready, out_valid, data_out, err_corr, err_uncorr, err_loc} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b ov=%b d=%h c=%b u=%b l=%0d want rdy=1 ov=0 d=0000 c=0 u=0 l=0",
               in_ready, out_valid, data_out, err_corr, err_uncorr, err_loc);
    end
    vectors++;
    if ({corr_cnt, uncorr_cnt, corr_cnt2, uncorr_cnt2} !== 36'd0) begin
      miscompares++;
      $display("FAIL reset_counters: got %0d %0d %0d %0d want all 0", corr_cnt, uncorr_cnt, corr_cnt2, uncorr_cnt2);
    end
  endtask

  task automatic test_known();
    logic [31:0] cws [4] = '{32'h40810001, 32'h00000020, 32'h0004FFFF, 32'h0000FFFC};
    logic [15:0] ed  [4] = '{16'h0001, 16'h0000, 16'hFFFF, 16'hFFFC};
    logic        ec  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic        eu  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [4:0]  el  [4] = '{5'd0, 5'd5, 5'd18, 5'd0};
    logic [15:0] ecc [4] = '{16'd0, 16'd1, 16'd2, 16'd2};
    logic [15:0] euc [4] = '{16'd0, 16'd0, 16'd0, 16'd1};
    for (int k = 0; k < 4; k++) begin
      step(1'b1, cws[k], 1'b1);
      step(1'b0, $urandom, 1'b1);
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL known%0d_latency1: got ov=%b want 0", k, out_valid);
      end
      step(1'b0, $urandom, 1'b1);
      vectors++;
      if ({out_valid, data_out, err_corr, err_uncorr, err_loc} !== {1'b1, ed[k], ec[k], eu[k], el[k]}) begin
        miscompares++;
        $display("FAIL known%0d_result: got ov=%b d=%h c=%b u=%b l=%0d want ov=1 d=%h c=%b u=%b l=%0d",
                 k, out_valid, data_out, err_corr, err_uncorr, err_loc, ed[k], ec[k], eu[k], el[k]);
      end
      step(1'b0, $urandom, 1'b1);
      vectors++;
      if ({out_valid, corr_cnt, uncorr_cnt} !== {1'b0, ecc[k], euc[k]}) begin
        miscompares++;
        $display("FAIL known%0d_counters: got ov=%b corr=%0d uncorr=%0d want ov=0 corr=%0d uncorr=%0d",
                 k, out_valid, corr_cnt, uncorr_cnt, ecc[k], euc[k]);
      end
    end
  endtask

  task automatic test_cnt_clr();
    cnt_clr = 1'b1;
    step(1'b0, $urandom, 1'b1);
    cnt_clr = 1'b0;
    step(1'b0, $urandom, 1'b1);
    vectors++;
    if ({corr_cnt, uncorr_cnt} !== 32'd0) begin
      miscompares++;
      $display("FAIL cnt_clr: got corr=%0d uncorr=%0d want 0 0", corr_cnt, uncorr_cnt);
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    logic v, r, exp_rdy, exp_ov;
    logic [31:0] cw;
    int mcorr = 0;
    int munc  = 0;
    for (int c = 0; c < 620; c++) begin
      v  = (c < 600) && ($urandom_range(0, 9) < 7);
      r  = (c >= 600) || ($urandom_range(0, 9) < 7);
      cw = rand_cw();
      step(v, cw, r);
      exp_rdy = (q.size() < 2) || r;
      exp_ov  = (q.size() > 0) && (c - q[0].t >= 2);
      vectors++;
      if ({in_ready, out_valid} !== {exp_rdy, exp_ov}) begin
        miscompares++;
        $display("FAIL rand_hs cyc %0d: got rdy=%b ov=%b want rdy=%b ov=%b", c, in_ready, out_valid, exp_rdy, exp_ov);
      end
      if (exp_ov) begin
        vectors++;
        if ({data_out, err_corr, err_uncorr, err_loc} !== {q[0].d, q[0].c, q[0].u, q[0].l}) begin
          miscompares++;
          $display("FAIL rand_out cyc %0d: got d=%h c=%b u=%b l=%0d want d=%h c=%b u=%b l=%0d",
                   c, data_out, err_corr, err_uncorr, err_loc, q[0].d, q[0].c, q[0].u, q[0].l);
        end
      end
      vectors++;
      if ({corr_cnt, uncorr_cnt} !== {16'(mcorr), 16'(munc)}) begin
        miscompares++;
        $display("FAIL rand_cnt cyc %0d: got corr=%0d uncorr=%0d want corr=%0d uncorr=%0d",
                 c, corr_cnt, uncorr_cnt, mcorr, munc);
      end
      if (exp_ov && r) begin
        e = q.pop_front();
        if (e.c) mcorr++;
        if (e.u) munc++;
      end
      if (v && exp_rdy) begin
        e = m_decode(cw);
        e.t = c;
        q.push_back(e);
      end
    end
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL rand_drain: got %0d results outstanding want 0", q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bcw [4];
    exp_t q[$];
    exp_t e;
    logic v, r, exp_rdy;
    int sent = 0;
    int got  = 0;
    logic saw_full = 1'b0;
    for (int k = 0; k < 4; k++) bcw[k] = rand_cw();
    for (int c = 0; c < 20; c++) begin
      v = (sent < 4);
      r = !(c >= 2 && c <= 4);
      step(v, v ? bcw[sent] : $urandom, r);
      exp_rdy = (q.size() < 2) || r;
      vectors++;
      if (in_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL b2b_ready cyc %0d: got %b want %b", c, in_ready, exp_rdy);
      end
      if (v && !exp_rdy) saw_full = 1'b1;
      if (out_valid && r) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_extra cyc %0d: got unexpected result d=%h want none", c, data_out);
        end else begin
          e = q.pop_front();
          if ({data_out, err_corr, err_uncorr, err_loc} !== {e.d, e.c, e.u, e.l}) begin
            miscompares++;
            $display("FAIL b2b_out #%0d: got d=%h c=%b u=%b l=%0d want d=%h c=%b u=%b l=%0d",
                     got, data_out, err_corr, err_uncorr, err_loc, e.d, e.c, e.u, e.l);
          end
          got++;
        end
      end
      if (v && exp_rdy) begin
        q.push_back(m_decode(bcw[sent]));
        sent++;
      end
    end
    vectors++;
    if ({got, saw_full} !== {32'd4, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_total: got %0d results full=%b want 4 full=1", got, saw_full);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] sc [5];
    exp_t se [5];
    int b, exp_cnt;
    for (int k = 0; k < 5; k++) begin
      sc[k] = encode(16'($urandom));
      b = $urandom_range(0, 31);
      sc[k][b] = ~sc[k][b];
      se[k] = m_decode(sc[k]);
    end
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      in_valid2 = (k < 5);
      cw_in2    = (k < 5) ? sc[k] : $urandom;
      cnt_clr2  = (k == 6);
      #1;
      exp_cnt = (k > 6 || k < 3) ? 0 : ((k - 2 > 3) ? 3 : k - 2);
      vectors++;
      if ({in_ready2, corr_cnt2, uncorr_cnt2} !== {1'b1, 2'(exp_cnt), 2'd0}) begin
        miscompares++;
        $display("FAIL sat_cnt cyc %0d: got rdy=%b corr=%0d uncorr=%0d want rdy=1 corr=%0d uncorr=0",
                 k, in_ready2, corr_cnt2, uncorr_cnt2, exp_cnt);
      end
      vectors++;
      if (k >= 2 && k <= 6) begin
        if ({out_valid2, data_out2, err_corr2, err_uncorr2, err_loc2} !== {1'b1, se[k-2].d, se[k-2].c, se[k-2].u, se[k-2].l}) begin
          miscompares++;
          $display("FAIL sat_out cyc %0d: got ov=%b d=%h c=%b u=%b l=%0d want ov=1 d=%h c=%b u=%b l=%0d",
                   k, out_valid2, data_out2, err_corr2, err_uncorr2, err_loc2,
                   se[k-2].d, se[k-2].c, se[k-2].u, se[k-2].l);
        end
      end else if (out_valid2 !== 1'b0) begin
        miscompares++;
        $display("FAIL sat_idle cyc %0d: got ov=%b want 0", k, out_valid2);
      end
    end
    in_valid2 = 1'b0;
    cnt_clr2  = 1'b0;
  endtask

  task automatic test_reset_midflight();
    logic [31:0] cwc;
    exp_t e;
    cwc = rand_cw();
    e   = m_decode(cwc);
    step(1'b1, rand_cw(), 1'b0);
    step(1'b1, rand_cw(), 1'b0);
    step(1'b0, $urandom, 1'b0);
    vectors++;
    if ({in_ready, out_valid} !== 2'b01) begin
      miscompares++;
      $display("FAIL mid_full: got rdy=%b ov=%b want rdy=0 ov=1", in_ready, out_valid);
    end
    rst = 1'b1;
    step(1'b0, $urandom, 1'b0);
    rst = 1'b0;
    step(1'b0, $urandom, 1'b1);
    vectors++;
    if ({in_ready, out_valid, data_out, err_corr, err_uncorr, err_loc, corr_cnt, uncorr_cnt} !==
        {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 5'd0, 16'd0, 16'd0}) begin
      miscompares++;
      $display("FAIL mid_reset: got rdy=%b ov=%b d=%h c=%b u=%b l=%0d corr=%0d uncorr=%0d want rdy=1 ov=0 all zero",
               in_ready, out_valid, data_out, err_corr, err_uncorr, err_loc, corr_cnt, uncorr_cnt);
    end
    step(1'b1, cwc, 1'b1);
    step(1'b0, $urandom, 1'b1);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_stale: got ov=%b want 0", out_valid);
    end
    step(1'b0, $urandom, 1'b1);
    vectors++;
    if ({out_valid, data_out, err_corr, err_uncorr, err_loc} !== {1'b1, e.d, e.c, e.u, e.l}) begin
      miscompares++;
      $display("FAIL mid_after: got ov=%b d=%h c=%b u=%b l=%0d want ov=1 d=%h c=%b u=%b l=%0d",
               out_valid, data_out, err_corr, err_uncorr, err_loc, e.d, e.c, e.u, e.l);
    end
    step(1'b0, $urandom, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; cw_in = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    in_valid2 = 1'b0; cw_in2 = '0; out_ready2 = 1'b1; cnt_clr2 = 1'b0;
    test_reset();
    test_known();
    test_cnt_clr();
    test_random();
    test_back_to_back();
    test_saturation();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
